// File: rtl/xop_fetch.sv
// xop_fetch: initiator side of the operand-read channel. Pulls remote operands
// into the local X buffer and re-queues fetches that time out.
module xop_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int EU_IDX_W   = 2,
    parameter int EU_IDX     = 0,
    parameter int QDEPTH     = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic [ADDR_WIDTH-1:0] icon_raddr,
    output logic                  icon_rready,
    input  logic                  icon_rvalid,
    input  logic [DATA_WIDTH-1:0] icon_rdata,
    output logic                  xw_valid,
    input  logic                  xw_ready,
    output logic [ADDR_WIDTH-1:0] xw_addr,
    output logic [DATA_WIDTH-1:0] xw_data,
    output logic                  req_local_err,
    output logic                  busy
);
    // state   | meaning
    // IDLE    | waiting; pops the FIFO head when an entry is queued
    // FETCH   | icon_rready high, waiting for remote data or timeout
    // DELIVER | xw_valid high, holding the captured operand for the X buffer
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DELIVER = 2'd2} state_t;

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]    CNT_FULL  = CNT_W'(QDEPTH);
    localparam logic [CNT_W-1:0]    CNT_RSV   = CNT_W'(QDEPTH - 1);
    localparam logic [TMR_W-1:0]    TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]    TMR_ONE   = TMR_W'(1);
    localparam logic [PTR_W-1:0]    PTR_ONE   = PTR_W'(1);
    localparam logic [EU_IDX_W-1:0] LOCAL_IDX = EU_IDX_W'(EU_IDX);

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] fifo_mem [QDEPTH];
    logic [PTR_W-1:0]      wptr, rptr, new_slot;
    logic [CNT_W-1:0]      count;
    logic [TMR_W-1:0]      timer;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  local_err_q;
    logic                  is_local, accept, push_new, push_retry, pop, timer_expired;

    always_comb begin
        is_local      = (req_addr[ADDR_WIDTH-1 -: EU_IDX_W] == LOCAL_IDX);
        accept        = req_valid && req_ready;
        push_new      = accept && !is_local;
        timer_expired = (timer == TMR_LAST);
        push_retry    = (state == FETCH) && !icon_rvalid && timer_expired;
        pop           = (state == IDLE) && (count != '0);
        // a retry and a new request in the same cycle land in consecutive slots, retry first
        new_slot      = push_retry ? (wptr + PTR_ONE) : wptr;
    end

    always_ff @(posedge clk) begin
        if (push_retry) fifo_mem[wptr] <= cur_addr;
        if (push_new)   fifo_mem[new_slot] <= req_addr;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            timer       <= '0;
            cur_addr    <= '0;
            cur_data    <= '0;
            local_err_q <= 1'b0;
        end else begin
            if (pop) begin
                cur_addr <= fifo_mem[rptr];
                rptr     <= rptr + PTR_ONE;
            end
            wptr  <= wptr + PTR_W'(push_retry) + PTR_W'(push_new);
            count <= count + CNT_W'(push_retry) + CNT_W'(push_new) - CNT_W'(pop);
            if ((state == FETCH) && !icon_rvalid && !timer_expired)
                timer <= timer + TMR_ONE;
            else
                timer <= '0;
            if ((state == FETCH) && icon_rvalid)
                cur_data <= icon_rdata;
            local_err_q <= accept && is_local;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (count != '0) state_nxt = FETCH;
            // data arriving in the last timeout cycle wins over the retry
            FETCH:   if (icon_rvalid)        state_nxt = DELIVER;
                     else if (timer_expired) state_nxt = IDLE;
            DELIVER: if (xw_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = (state == IDLE) ? (count < CNT_FULL) : (count < CNT_RSV);
        icon_rready   = (state == FETCH);
        icon_raddr    = cur_addr;
        xw_valid      = (state == DELIVER);
        xw_addr       = cur_addr;
        xw_data       = cur_data;
        req_local_err = local_err_q;
        busy          = (state != IDLE) || (count != '0);
    end
endmodule
